// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the decode-stage immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_SHAMT = 3'd2,
        IMM_S     = 3'd3,
        IMM_B     = 3'd4,
        IMM_U     = 3'd5,
        IMM_J     = 3'd6
    } imm_type_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: format chosen from the opcode, result sign-extended to XLEN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    // Every format is first built as a 32-bit signed value, then widened once below.
    logic [31:0] raw;

    // Opcode-driven format selection and field assembly.
    always_comb begin
        raw      = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (instr[6:0])
            OP_IMM: begin
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
                    imm_type = IMM_SHAMT;
                    // shamt is unsigned; RV64 uses one extra bit
                    if (XLEN == 64) raw = {26'd0, instr[25:20]};
                    else            raw = {27'd0, instr[24:20]};
                end else begin
                    imm_type = IMM_I;
                    raw      = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                imm_type = IMM_I;
                raw      = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                imm_type = IMM_S;
                raw      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                imm_type = IMM_B;
                raw      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                imm_type = IMM_U;
                raw      = {instr[31:12], 12'd0};
            end
            OP_JAL: begin
                imm_type = IMM_J;
                raw      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_REG: ;
            default: illegal = 1'b1;
        endcase
    end

    // Bit 31 of the 32-bit form fills the upper half on RV64.
    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer toward execute.
// Optional macro IMM_TARGET_EN adds out_target = in_pc + imm, registered with each entry.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_pc,
`ifdef IMM_TARGET_EN
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_target
`else
    output logic [TAG_W-1:0] out_tag
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_type_e        imm_type;
        logic             illegal;
        logic [XLEN-1:0]  pc;
        logic [TAG_W-1:0] tag;
`ifdef IMM_TARGET_EN
        logic [XLEN-1:0]  target;
`endif
    } entry_t;

    entry_t          new_entry, main_q, main_d, skid_q, skid_d;
    logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic            accept, consume;
    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illegal;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .imm_type(dec_type),
        .illegal (dec_illegal)
    );

    // Assemble the entry captured on accept.
    always_comb begin
        new_entry          = '0;
        new_entry.imm      = dec_imm;
        new_entry.imm_type = dec_type;
        new_entry.illegal  = dec_illegal;
        new_entry.pc       = in_pc;
        new_entry.tag      = in_tag;
`ifdef IMM_TARGET_EN
        // NONE entries carry imm=0, so the target degenerates to the PC.
        new_entry.target   = in_pc + dec_imm;
`endif
    end

    assign accept  = in_valid && !skid_valid_q;
    assign consume = main_valid_q && out_ready;

    // Skid-buffer next state; flush wins over everything, data loads only on accept/shift.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                // accept is impossible here since in_ready is low
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_type    = main_q.imm_type;
    assign out_illegal = main_q.illegal;
    assign out_pc      = main_q.pc;
    assign out_tag     = main_q.tag;
`ifdef IMM_TARGET_EN
    assign out_target  = main_q.target;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances driven in lockstep,
// directed cases plus random traffic against a FIFO/arith reference model.
module tb_imm_gen_stage;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic [4:0]  in_tag;

    logic        o32_valid, o32_ready, o32_ill, o64_valid, o64_ready, o64_ill;
    logic [31:0] o32_imm, o32_pc, o32_target;
    logic [63:0] o64_imm, o64_pc, o64_target;
    logic [2:0]  o32_type, o64_type;
    logic [4:0]  o32_tag, o64_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [4:0]  tag;
    } txn_t;
    txn_t q[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o32_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_tag(in_tag), .out_valid(o32_valid),
        .out_ready(out_ready), .out_imm(o32_imm), .out_type(o32_type),
        .out_illegal(o32_ill), .out_pc(o32_pc),
`ifdef IMM_TARGET_EN
        .out_tag(o32_tag), .out_target(o32_target)
`else
        .out_tag(o32_tag)
`endif
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o64_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_tag(in_tag), .out_valid(o64_valid),
        .out_ready(out_ready), .out_imm(o64_imm), .out_type(o64_type),
        .out_illegal(o64_ill), .out_pc(o64_pc),
`ifdef IMM_TARGET_EN
        .out_tag(o64_tag), .out_target(o64_target)
`else
        .out_tag(o64_tag)
`endif
    );

`ifndef IMM_TARGET_EN
    assign o32_target = '0;
    assign o64_target = '0;
`endif

    // Reference: immediate as an integer value derived from the format rules.
    function automatic void ref_decode(input logic [31:0] instr, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] typ,
                                       output logic ill);
        longint v;
        v = 0; typ = IMM_NONE; ill = 1'b0;
        case (instr[6:0])
            7'h13: begin
                if (instr[14:12] == 3'd1 || instr[14:12] == 3'd5) begin
                    typ = IMM_SHAMT;
                    v = (xlen == 64) ? longint'(instr[25:20]) : longint'(instr[24:20]);
                end else begin
                    typ = IMM_I; v = $signed(instr[31:20]);
                end
            end
            7'h03, 7'h67, 7'h73: begin typ = IMM_I; v = $signed(instr[31:20]); end
            7'h23: begin typ = IMM_S; v = $signed({instr[31:25], instr[11:7]}); end
            7'h63: begin
                typ = IMM_B;
                v = $signed({instr[31], instr[7], instr[30:25], instr[11:8]});
                v = v * 2;
            end
            7'h37, 7'h17: begin typ = IMM_U; v = $signed(instr[31:12]); v = v * 4096; end
            7'h6F: begin
                typ = IMM_J;
                v = $signed({instr[31], instr[19:12], instr[20], instr[30:21]});
                v = v * 2;
            end
            7'h33: ;
            default: ill = 1'b1;
        endcase
        imm = v;
        if (xlen == 32) imm[63:32] = '0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_drain();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_tag = '0;
        #12;
        n_checks++;
        if ({o32_valid, o32_ready, o32_imm, o32_type, o32_ill, o32_pc, o32_tag, o32_target}
            !== {1'b0, 1'b1, 105'd0}) begin
            n_fail++;
            $display("FAIL reset32: got v=%b r=%b imm=%h pc=%h tag=%h tgt=%h want v=0 r=1 rest 0",
                     o32_valid, o32_ready, o32_imm, o32_pc, o32_tag, o32_target);
        end
        n_checks++;
        if ({o64_valid, o64_ready, o64_imm, o64_type, o64_ill, o64_pc, o64_tag, o64_target}
            !== {1'b0, 1'b1, 201'd0}) begin
            n_fail++;
            $display("FAIL reset64: got v=%b r=%b imm=%h pc=%h tag=%h tgt=%h want v=0 r=1 rest 0",
                     o64_valid, o64_ready, o64_imm, o64_pc, o64_tag, o64_target);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_i_type();
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h40; in_tag = 5'd3; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if ({o32_valid, o32_imm, o32_type, o32_tag} !== {1'b1, 32'hFFFFFFFF, 3'd1, 5'd3}) begin
            n_fail++;
            $display("FAIL addi32: got v=%b imm=%h type=%0d tag=%0d want v=1 imm=ffffffff type=1 tag=3",
                     o32_valid, o32_imm, o32_type, o32_tag);
        end
        n_checks++;
        if ({o64_valid, o64_imm, o64_type} !== {1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1}) begin
            n_fail++;
            $display("FAIL addi64: got v=%b imm=%h type=%0d want v=1 imm=all-ones type=1",
                     o64_valid, o64_imm, o64_type);
        end
        idle_drain();
    endtask

    task automatic test_b_type();
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 64'h100; in_tag = 5'd4; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if ({o32_valid, o32_imm, o32_type} !== {1'b1, 32'hFFFFFFFC, 3'd4}) begin
            n_fail++;
            $display("FAIL beq32: got v=%b imm=%h type=%0d want v=1 imm=fffffffc type=4",
                     o32_valid, o32_imm, o32_type);
        end
        n_checks++;
        if ({o64_imm, o64_type} !== {64'hFFFFFFFFFFFFFFFC, 3'd4}) begin
            n_fail++;
            $display("FAIL beq64: got imm=%h type=%0d want imm=fffffffffffffffc type=4",
                     o64_imm, o64_type);
        end
`ifdef IMM_TARGET_EN
        n_checks++;
        if ({o32_target, o64_target} !== {32'hFC, 64'hFC}) begin
            n_fail++;
            $display("FAIL beq_target: got %h / %h want fc / fc", o32_target, o64_target);
        end
`endif
        idle_drain();
    endtask

    task automatic test_xlen64();
        in_valid = 1'b1; in_instr = 32'h800000B7; in_pc = 64'h200; out_ready = 1'b1;
        cycle();
        in_instr = 32'h03F09093;
        n_checks++;
        if ({o64_imm, o64_type, o32_imm} !== {64'hFFFFFFFF80000000, 3'd5, 32'h80000000}) begin
            n_fail++;
            $display("FAIL lui: got imm64=%h type=%0d imm32=%h want ffffffff80000000 5 80000000",
                     o64_imm, o64_type, o32_imm);
        end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if ({o64_valid, o64_imm, o64_type, o32_imm, o32_type}
            !== {1'b1, 64'h3F, 3'd2, 32'h1F, 3'd2}) begin
            n_fail++;
            $display("FAIL slli: got v=%b imm64=%h t=%0d imm32=%h t=%0d want 1 3f 2 1f 2",
                     o64_valid, o64_imm, o64_type, o32_imm, o32_type);
        end
        idle_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_imm [3] = '{32'd1, 32'd2, 32'd3};
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00100093; in_tag = 5'd1; cycle();
        in_instr = 32'h00200093; in_tag = 5'd2; cycle();
        in_instr = 32'h00300093; in_tag = 5'd3;
        cycle();
        n_checks++;
        if ({o32_valid, o32_ready, o64_ready, o32_imm, o32_tag} !== {3'b100, 32'd1, 5'd1}) begin
            n_fail++;
            $display("FAIL full_hold: got v=%b r32=%b r64=%b imm=%h tag=%0d want 1 0 0 1 1",
                     o32_valid, o32_ready, o64_ready, o32_imm, o32_tag);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            cycle();
            if (k == 2) in_valid = 1'b0;
            n_checks++;
            if ({o32_valid, o32_imm, o32_tag} !== {1'b1, exp_imm[k], 5'(k + 1)}) begin
                n_fail++;
                $display("FAIL drain_%0d: got v=%b imm=%h tag=%0d want 1 %h %0d",
                         k, o32_valid, o32_imm, o32_tag, exp_imm[k], k + 1);
            end
        end
        cycle();
        n_checks++;
        if ({o32_valid, o64_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL drain_empty: got v32=%b v64=%b want 0 0", o32_valid, o64_valid);
        end
        idle_drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00100093; cycle();
        in_instr = 32'h00200093; cycle();
        flush = 1'b1; in_instr = 32'h00700093; in_tag = 5'd7;
        cycle();
        n_checks++;
        if ({o32_valid, o32_ready, o64_valid, o64_ready} !== 4'b0101) begin
            n_fail++;
            $display("FAIL flush_full: got v32=%b r32=%b v64=%b r64=%b want 0 1 0 1",
                     o32_valid, o32_ready, o64_valid, o64_ready);
        end
        // Flush on an empty buffer with a same-cycle input: that input is dropped too.
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({o32_valid, o64_valid, o32_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL flush_drop_%0d: got v32=%b v64=%b r=%b want 0 0 1",
                         k, o32_valid, o64_valid, o32_ready);
            end
            cycle();
        end
    endtask

    task automatic test_illegal_and_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 64'h300;
        cycle();
        in_instr = 32'h002081B3;
        n_checks++;
        if ({o32_valid, o32_ill, o32_imm, o32_type, o64_ill, o64_imm, o64_type}
            !== {2'b11, 35'd0, 1'b1, 67'd0}) begin
            n_fail++;
            $display("FAIL illegal: got v=%b ill=%b imm=%h t=%0d ill64=%b imm64=%h want 1 1 0 0 1 0",
                     o32_valid, o32_ill, o32_imm, o32_type, o64_ill, o64_imm);
        end
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if ({o32_valid, o32_ill, o32_imm, o32_type} !== {2'b10, 35'd0}) begin
            n_fail++;
            $display("FAIL rtype: got v=%b ill=%b imm=%h t=%0d want 1 0 0 0",
                     o32_valid, o32_ill, o32_imm, o32_type);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o32_valid, o32_ready, o64_valid, o64_ready, o32_imm} !== {4'b0101, 32'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got v32=%b r32=%b v64=%b r64=%b imm=%h want 0 1 0 1 0",
                     o32_valid, o32_ready, o64_valid, o64_ready, o32_imm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_random();
        logic        exp_valid, exp_ready, ill;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                                  7'h6F, 7'h33};
        logic [31:0] r;
        logic [72:0]  e32, g32;
        logic [136:0] e64, g64;
        txn_t t, h;
        for (int c = 0; c < 400; c++) begin
            exp_valid = (q.size() != 0);
            exp_ready = (q.size() < 2);
            n_checks++;
            if ({o32_valid, o32_ready, o64_valid, o64_ready} !== {2{exp_valid, exp_ready}}) begin
                n_fail++;
                $display("FAIL rnd_hs cyc %0d: got %b%b %b%b want v=%b r=%b", c, o32_valid,
                         o32_ready, o64_valid, o64_ready, exp_valid, exp_ready);
            end
            if (exp_valid) begin
                h = q[0];
                ref_decode(h.instr, 32, imm, typ, ill);
                e32 = {typ, ill, imm[31:0], h.pc[31:0], h.tag};
                g32 = {o32_type, o32_ill, o32_imm, o32_pc, o32_tag};
                n_checks++;
                if (g32 !== e32) begin
                    n_fail++;
                    $display("FAIL rnd_data32 cyc %0d instr %h: got %h want %h", c, h.instr, g32, e32);
                end
`ifdef IMM_TARGET_EN
                n_checks++;
                if (o32_target !== h.pc[31:0] + imm[31:0]) begin
                    n_fail++;
                    $display("FAIL rnd_tgt32 cyc %0d: got %h want %h", c, o32_target,
                             h.pc[31:0] + imm[31:0]);
                end
`endif
                ref_decode(h.instr, 64, imm, typ, ill);
                e64 = {typ, ill, imm, h.pc, h.tag};
                g64 = {o64_type, o64_ill, o64_imm, o64_pc, o64_tag};
                n_checks++;
                if (g64 !== e64) begin
                    n_fail++;
                    $display("FAIL rnd_data64 cyc %0d instr %h: got %h want %h", c, h.instr, g64, e64);
                end
`ifdef IMM_TARGET_EN
                n_checks++;
                if (o64_target !== h.pc + imm) begin
                    n_fail++;
                    $display("FAIL rnd_tgt64 cyc %0d: got %h want %h", c, o64_target, h.pc + imm);
                end
`endif
            end
            r = $urandom();
            t.instr = (r[3:0] < 4'd14) ? {r[31:7], ops[$urandom_range(0, 9)]} : r;
            t.pc    = {$urandom(), $urandom()};
            t.tag   = 5'($urandom());
            in_instr  = t.instr; in_pc = t.pc; in_tag = t.tag;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (exp_valid && out_ready) void'(q.pop_front());
                if (in_valid && exp_ready) q.push_back(t);
            end
            @(negedge clk);
        end
        idle_drain();
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_b_type();
        test_xlen64();
        test_back_to_back();
        test_flush();
        test_illegal_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, registered immediate generator for the decode stage of the 5-stage RV32I/RV64I pipeline.
- Decodes the immediate format directly from the opcode instead of taking an external select.
- Supports I, shift-amount, S, B, U and J formats, sign-extended to XLEN.
- Presents the result through a 2-entry skid buffer with valid/ready handshake and flush, giving a registered in_ready toward fetch and a 1-cycle latency toward execute.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 5, width of the opaque sideband tag carried with each instruction (e.g. rd index).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  drops all buffered entries and any same-cycle input.
in_valid  input  1  instruction word presented.
in_ready  output  1  stage can accept; equals !skid_valid, registered.
in_instr  input  32  raw instruction.
in_pc  input  XLEN  instruction PC.
in_tag  input  TAG_W  sideband, passed through unchanged.
out_valid  output  1  main register holds a valid entry.
out_ready  input  1  execute stage accepts.
out_imm  output  XLEN  extended immediate.
out_type  output  3  imm_type_e of the entry.
out_illegal  output  1  opcode has no defined immediate format.
out_pc  output  XLEN  PC of the entry.
out_tag  output  TAG_W  tag of the entry.

Behaviour:
- Reset (rst_n low, async): main_valid=0, skid_valid=0, all data registers 0, so every output is 0 except in_ready=1.
- Decode, combinational on in_instr[6:0]:
  - 0010011 with funct3 001/101 -> SHAMT; immediate is zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  - Other 0010011, plus 0000011, 1100111, 1110011 -> I: sext(instr[31:20]).
  - 0100011 -> S: sext({instr[31:25],instr[11:7]}).
  - 1100011 -> B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 0110111, 0010111 -> U: sext({instr[31:12],12'b0}); upper bits are sign-filled from bit 31 when XLEN=64.
  - 1101111 -> J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 0110011 (R-type) -> NONE, imm=0, illegal=0.
  - Any other opcode -> NONE, imm=0, illegal=1.
- Accept: in_valid && in_ready.
  - Decoded entry goes to main if main is empty or is being consumed this cycle (out_valid && out_ready); otherwise it goes to skid.
- Consume: out_valid && out_ready.
  - If skid is valid, skid moves to main and skid clears.
  - Otherwise main clears, unless a new entry is accepted into main in the same cycle.
- Latency: accepted in cycle N -> visible on outputs in cycle N+1 when the buffer was empty.
- Throughput: 1 per cycle while out_ready=1.
- Full (skid_valid=1): in_ready=0 and input is ignored.
- Ordering: strict FIFO; the skid entry never overtakes main.
- Flush: has priority over accept and consume.
  - Next edge: main_valid=skid_valid=0 and in_ready=1.
  - Data registers keep stale values while valid=0.
- Reset asserted mid-transfer drops all entries immediately.
- Data registers load only on accept or shift, so there is no toggling while stalled.

Optional Feature:
Macro IMM_TARGET_EN.
- Defined: adds output out_target (XLEN), registered alongside main/skid as in_pc + imm, mod 2^XLEN, wrapping silently.
  - For NONE entries, out_target = in_pc.
  - Used by execute for early branch/JAL target.
  - Reset value 0.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_type_e: IMM_NONE=0, IMM_I=1, IMM_SHAMT=2, IMM_S=3, IMM_B=4, IMM_U=5, IMM_J=6.
  - Opcode localparams: OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG.
- One natural sub-module: imm_decode, purely combinational (instr -> imm, type, illegal), parametrised by XLEN.
- The top level holds the skid buffer and the optional adder.

Test Plan:
- XLEN=32, feed 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_type=IMM_I.
- Feed B-type 0xFE000EE3 (beq x0,x0,-4), in_pc=0x100 -> out_imm=0xFFFFFFFC, out_type=IMM_B; with IMM_TARGET_EN, out_target=0xFC.
- XLEN=64, feed LUI 0x800000B7 -> out_imm=0xFFFFFFFF80000000; feed slli 0x03F09093 -> out_imm=0x3F, out_type=IMM_SHAMT.
- out_ready=0, three back-to-back valid inputs A,B,C -> A in main, B in skid, in_ready=0 and C held; raise out_ready -> outputs A, B, C on consecutive cycles.
- Buffer full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- Feed opcode 0x7F -> out_illegal=1, out_imm=0, out_type=IMM_NONE; assert rst_n=0 mid-stream -> out_valid drops asynchronously and in_ready=1.
